// File: rtl/nes_alu_pkg.sv
// nes_alu_pkg: shared types and constants for the
// sequential NES ALU and its BCD nibble stage.
package nes_alu_pkg;

  typedef enum logic [2:0] {
    FN_OR    = 3'b000,
    FN_AND   = 3'b001,
    FN_XOR   = 3'b010,
    FN_ADC   = 3'b011,
    FN_SBC   = 3'b100,
    FN_CMP   = 3'b101,
    FN_BIT   = 3'b110,
    FN_PASSB = 3'b111
  } alu_funct_e;

  typedef enum logic [1:0] {
    OPB_SHR = 2'b00,
    OPB_SHL = 2'b01,
    OPB_INC = 2'b10,
    OPB_DEC = 2'b11
  } alu_opb_funct_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DADJ = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  localparam logic [3:0] BCD_ADJ = 4'd6;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/nes_alu_seq_bcd.sv
// nes_bcd_nibble: one decimal digit of BCD add/subtract.
// cin/cout are carry for add, borrow for subtract.
module nes_bcd_nibble
  import nes_alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;

  // 5-bit raw sum/difference, then decimal correction mod 16
  always_comb begin
    s     = '0;
    cout  = 1'b0;
    digit = '0;
    if (!sub) begin
      s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      cout  = (s > {1'b0, BCD_MAX});
      digit = cout ? (s[3:0] + BCD_ADJ) : s[3:0];
    end else begin
      s     = {1'b0, a} - {1'b0, b} - {4'b0, cin};
      cout  = s[4];
      digit = cout ? (s[3:0] - BCD_ADJ) : s[3:0];
    end
  end

endmodule

// File: rtl/nes_alu_seq.sv
// nes_alu_seq: registered ALU with serial BCD adjust
// and valid/ready handshakes on request and response.
module nes_alu_seq
  import nes_alu_pkg::*;
#(
  parameter int NumB  = 8,
  parameter bit DecEn = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [NumB-1:0] OpA,
  input  logic [NumB-1:0] OpB,
  input  logic [2:0]      ALU_Funct,
  input  logic            ALU_OpB_FunctEn,
  input  logic [1:0]      ALU_OpB_Funct,
  input  logic            Cin,
  input  logic            DecMode,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [NumB-1:0] ALU_Rslt,
  output logic            NFlg,
  output logic            ZFlg,
  output logic            VFlg,
  output logic            CFlg
);

  localparam int NumDig = NumB / 4;
  localparam int NibW   = (NumDig > 2) ? $clog2(NumDig) : 1;

  if ((NumB % 4) != 0 || NumB < 8) begin : gBadNumB
    $error("NumB must be a multiple of 4 and at least 8");
  end

  alu_funct_e     fn;
  alu_opb_funct_e ofn;
  alu_state_e     state;

  logic [NumB-1:0] opBp;
  logic            cs;
  logic [NumB:0]   sum;
  logic [NumB-1:0] binR;
  logic            binN, binZ, binV, binC;
  logic            accept, isDec;

  logic [NibW-1:0] nib;
  logic [NumB-1:0] aReg, bReg, decR, decRes;
  logic            carry, subOp, vDec;
  logic [3:0]      digit;
  logic            cout;

  assign fn  = alu_funct_e'(ALU_Funct);
  assign ofn = alu_opb_funct_e'(ALU_OpB_Funct);

  assign req_ready = (state == ST_IDLE) ||
                     (state == ST_DONE && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign isDec     = DecEn && DecMode &&
                     (fn == FN_ADC || fn == FN_SBC);

  // OpB pre-op followed by the single-cycle binary ops
  always_comb begin
    opBp = OpB;
    cs   = 1'b0;
    if (ALU_OpB_FunctEn) begin
      unique case (1'b1)
        (ofn == OPB_SHR): {opBp, cs} = {Cin, OpB};
        (ofn == OPB_SHL): {cs, opBp} = {OpB, Cin};
        (ofn == OPB_INC): {cs, opBp} = {1'b0, OpB} + 1'b1;
        (ofn == OPB_DEC): {cs, opBp} = {1'b0, OpB} - 1'b1;
        default: ;
      endcase
    end
    sum  = '0;
    binR = '0;
    binC = cs;
    binV = 1'b0;
    unique case (1'b1)
      (fn == FN_OR):  binR = OpA | opBp;
      (fn == FN_AND): binR = OpA & opBp;
      (fn == FN_XOR): binR = OpA ^ opBp;
      (fn == FN_ADC): begin
        sum  = {1'b0, OpA} + {1'b0, opBp} + {{NumB{1'b0}}, Cin};
        binR = sum[NumB-1:0];
        binC = sum[NumB];
        binV = (OpA[NumB-1] == opBp[NumB-1]) &&
               (binR[NumB-1] != OpA[NumB-1]);
      end
      (fn == FN_SBC): begin
        sum  = {1'b0, OpA} + {1'b0, ~opBp} + {{NumB{1'b0}}, Cin};
        binR = sum[NumB-1:0];
        binC = sum[NumB];
        binV = (OpA[NumB-1] != opBp[NumB-1]) &&
               (binR[NumB-1] != OpA[NumB-1]);
      end
      (fn == FN_CMP): begin
        sum  = {1'b0, OpA} - {1'b0, opBp};
        binR = sum[NumB-1:0];
        binC = ~sum[NumB];
      end
      (fn == FN_BIT): begin
        binR = OpA & opBp;
        binV = opBp[NumB-2];
      end
      (fn == FN_PASSB): binR = opBp;
      default: ;
    endcase
    binN = (fn == FN_BIT) ? opBp[NumB-1] : binR[NumB-1];
    binZ = (binR == '0);
  end

  nes_bcd_nibble uNib (
    .a     (aReg[3:0]),
    .b     (bReg[3:0]),
    .cin   (carry),
    .sub   (subOp),
    .digit (digit),
    .cout  (cout)
  );

  assign decRes = {digit, decR[NumB-1:4]};

  // Control FSM with registered response and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      ALU_Rslt  <= '0;
      NFlg      <= 1'b0;
      ZFlg      <= 1'b1;
      VFlg      <= 1'b0;
      CFlg      <= 1'b0;
      nib       <= '0;
      aReg      <= '0;
      bReg      <= '0;
      decR      <= '0;
      carry     <= 1'b0;
      subOp     <= 1'b0;
      vDec      <= 1'b0;
    end else if (state == ST_DADJ) begin
      aReg  <= aReg >> 4;
      bReg  <= bReg >> 4;
      carry <= cout;
      decR  <= decRes;
      nib   <= nib + NibW'(1);
      if (nib == NibW'(NumDig - 1)) begin
        state     <= ST_DONE;
        rsp_valid <= 1'b1;
        ALU_Rslt  <= decRes;
        NFlg      <= decRes[NumB-1];
        ZFlg      <= (decRes == '0);
        VFlg      <= vDec;
        CFlg      <= subOp ? ~cout : cout;
      end
    end else if (accept) begin
      if (isDec) begin
        state     <= ST_DADJ;
        rsp_valid <= 1'b0;
        nib       <= '0;
        aReg      <= OpA;
        bReg      <= opBp;
        decR      <= '0;
        subOp     <= (fn == FN_SBC);
        carry     <= (fn == FN_SBC) ? ~Cin : Cin;
        vDec      <= binV;
      end else begin
        state     <= ST_DONE;
        rsp_valid <= 1'b1;
        ALU_Rslt  <= binR;
        NFlg      <= binN;
        ZFlg      <= binZ;
        VFlg      <= binV;
        CFlg      <= binC;
      end
    end else if (state == ST_DONE && rsp_ready) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_alu_seq.sv
// tb_nes_alu_seq: directed and random checks of nes_alu_seq
// against an arithmetic reference model with a response queue.
module tb_nes_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] OpA = '0;
  logic [7:0] OpB = '0;
  logic [2:0] ALU_Funct = '0;
  logic       ALU_OpB_FunctEn = 1'b0;
  logic [1:0] ALU_OpB_Funct = '0;
  logic       Cin = 1'b0;
  logic       DecMode = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] ALU_Rslt;
  logic       NFlg, ZFlg, VFlg, CFlg;

  nes_alu_seq #(.NumB(8), .DecEn(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .OpA             (OpA),
    .OpB             (OpB),
    .ALU_Funct       (ALU_Funct),
    .ALU_OpB_FunctEn (ALU_OpB_FunctEn),
    .ALU_OpB_Funct   (ALU_OpB_Funct),
    .Cin             (Cin),
    .DecMode         (DecMode),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .ALU_Rslt        (ALU_Rslt),
    .NFlg            (NFlg),
    .ZFlg            (ZFlg),
    .VFlg            (VFlg),
    .CFlg            (CFlg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int n; int z; int v; int c;
    int lat; int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  bit   randMode = 1'b0;
  bit   dirReady = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on operand values/digits
  function automatic exp_t model(input int a, input int b,
      input int f, input int en, input int of,
      input int ci, input int dm);
    exp_t e;
    int bp, cs, s, t, k, da, db, d;
    bp = b; cs = 0;
    if (en != 0) begin
      case (of)
        0: begin cs = b % 2;       bp = b / 2 + ci * 128; end
        1: begin cs = b / 128;     bp = (b * 2) % 256 + ci; end
        2: begin cs = (b == 255);  bp = (b + 1) % 256; end
        default: begin cs = (b == 0); bp = (b + 255) % 256; end
      endcase
    end
    e.v = 0; e.c = cs; e.r = 0;
    case (f)
      0: e.r = a | bp;
      1: e.r = a & bp;
      2: e.r = a ^ bp;
      3: begin
        s = a + bp + ci; e.r = s % 256; e.c = (s > 255);
        t = sgn(a) + sgn(bp) + ci; e.v = (t > 127 || t < -128);
      end
      4: begin
        s = a - bp - (1 - ci); e.r = (s + 256) % 256; e.c = (s >= 0);
        t = sgn(a) - sgn(bp) - (1 - ci); e.v = (t > 127 || t < -128);
      end
      5: begin e.r = (a - bp + 256) % 256; e.c = (a >= bp); end
      6: begin e.r = a & bp; e.v = (bp / 64) % 2; end
      default: e.r = bp;
    endcase
    e.lat = 1;
    if (dm != 0 && (f == 3 || f == 4)) begin
      e.lat = 3; e.r = 0;
      k = (f == 3) ? ci : 1 - ci;
      for (int i = 0; i < 2; i++) begin
        da = (a >> (4 * i)) % 16;
        db = (bp >> (4 * i)) % 16;
        if (f == 3) begin
          s = da + db + k;
          if (s > 9) begin s = s + 6; k = 1; end else k = 0;
          e.r = e.r + ((s % 16) << (4 * i));
        end else begin
          d = da - db - k;
          if (d < 0) begin d = d - 6; k = 1; end else k = 0;
          e.r = e.r + (((d + 32) % 16) << (4 * i));
        end
      end
      e.c = (f == 3) ? k : 1 - k;
    end
    e.n = (f == 6) ? bp / 128 : e.r / 128;
    e.z = (e.r == 0);
    e.due = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    rsp_ready = randMode ? ($urandom_range(0, 3) != 0) : dirReady;
  end

  // Scoreboard: handshake timing and results every cycle
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (rst) begin
      q.delete();
    end else if (started) begin
      ev = (q.size() > 0) && (q[0].due <= cyc);
      chk("rsp_valid", rsp_valid, ev);
      chk("req_ready", req_ready,
          (q.size() == 0) || (ev && rsp_ready));
      if (ev && rsp_valid === 1'b1)
        chk("rsp_data", {ALU_Rslt, NFlg, ZFlg, VFlg, CFlg},
            {q[0].r[7:0], q[0].n[0], q[0].z[0],
             q[0].v[0], q[0].c[0]});
      if (ev && rsp_ready) void'(q.pop_front());
      if (req_valid && req_ready === 1'b1) begin
        e = model(OpA, OpB, ALU_Funct, ALU_OpB_FunctEn,
                  ALU_OpB_Funct, Cin, DecMode);
        e.due = cyc + e.lat;
        q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReq(input logic [7:0] a, input logic [7:0] b,
      input logic [2:0] f, input logic en, input logic [1:0] of,
      input logic ci, input logic dm, output int w);
    bit ok;
    ok = 1'b0; w = 0;
    OpA = a; OpB = b; ALU_Funct = f;
    ALU_OpB_FunctEn = en; ALU_OpB_Funct = of;
    Cin = ci; DecMode = dm; req_valid = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1'b1; w = i; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic expectRsp(input string nm, input logic [7:0] r,
      input logic n, input logic z, input logic v, input logic c,
      input int lat);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin k = i; break; end
      chk({nm, "_busy"}, req_ready, 1'b0);
    end
    chk({nm, "_lat"}, k, lat);
    if (k != 0)
      chk(nm, {ALU_Rslt, NFlg, ZFlg, VFlg, CFlg}, {r, n, z, v, c});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) step();
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_state", {rsp_valid, req_ready, ALU_Rslt,
        NFlg, ZFlg, VFlg, CFlg}, {1'b0, 1'b1, 8'h00,
        1'b0, 1'b1, 1'b0, 1'b0});
    step();

    doReq(8'h50, 8'h50, 3'd3, 0, 2'd0, 0, 0, w);
    expectRsp("adc_bin", 8'hA0, 1, 0, 1, 0, 1);
    step();
    doReq(8'h58, 8'h46, 3'd3, 0, 2'd0, 1, 1, w);
    expectRsp("adc_dec", 8'h05, 0, 0, 1, 1, 3);
    step();
    doReq(8'h12, 8'h21, 3'd4, 0, 2'd0, 1, 1, w);
    expectRsp("sbc_dec_neg", 8'h91, 1, 0, 0, 0, 3);
    step();
    doReq(8'h21, 8'h12, 3'd4, 0, 2'd0, 1, 1, w);
    expectRsp("sbc_dec_pos", 8'h09, 0, 0, 0, 1, 3);
    step();
    doReq(8'h00, 8'h80, 3'd0, 1, 2'd1, 0, 0, w);
    expectRsp("shl_or", 8'h00, 0, 1, 0, 1, 1);
    step();
    doReq(8'h10, 8'h10, 3'd5, 0, 2'd0, 0, 0, w);
    expectRsp("cmp_eq", 8'h00, 0, 1, 0, 1, 1);
    step();
    doReq(8'hFF, 8'h40, 3'd6, 0, 2'd0, 0, 0, w);
    expectRsp("bit", 8'h40, 0, 0, 1, 0, 1);
    step();

    dirReady = 1'b0;
    doReq(8'h50, 8'h50, 3'd3, 0, 2'd0, 0, 0, w);
    expectRsp("bp_first", 8'hA0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, req_ready, ALU_Rslt,
          NFlg, ZFlg, VFlg, CFlg}, {1'b1, 1'b0, 8'hA0,
          1'b1, 1'b0, 1'b1, 1'b0});
    end
    step();
    dirReady = 1'b1;
    doReq(8'h10, 8'h10, 3'd5, 0, 2'd0, 0, 0, w);
    chk("bp_accept_wait", w, 1);
    expectRsp("bp_next", 8'h00, 0, 1, 0, 1, 1);
    step();

    doReq(8'h58, 8'h46, 3'd3, 0, 2'd0, 1, 1, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dadj", {rsp_valid, req_ready, ALU_Rslt,
        NFlg, ZFlg, VFlg, CFlg}, {1'b0, 1'b1, 8'h00,
        1'b0, 1'b1, 1'b0, 1'b0});
    step();
    doReq(8'h21, 8'h12, 3'd4, 0, 2'd0, 1, 1, w);
    expectRsp("after_rst", 8'h09, 0, 0, 0, 1, 3);
    step();

    randMode = 1'b1;
    repeat (300) begin
      doReq(8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), w);
      repeat ($urandom_range(0, 2)) step();
    end
    randMode = 1'b0;
    dirReady = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("drain", q.size(), 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
